// File: rtl/prf_scoreboard.sv
// Physical register file with a per-register ready scoreboard.
// Rename allocation marks destinations busy, writeback stores data and clears
// busy, and read ports return data plus a ready flag with same-cycle bypass.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               clears every busy bit at the next edge
//   alloc_en/alloc_tag  NUM_AL allocate ports (tag k = [k*AW +: AW])
//   wr_en/wr_addr/wr_data  NUM_WR writeback ports
//   rd_addr             NUM_RD read addresses
//   rd_data/rd_ready    combinational read data and ready flags
//   busy_cnt            registered popcount of the busy vector
module prf_scoreboard #(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned DEPTH  = 64,
  parameter  int unsigned NUM_RD = 8,
  parameter  int unsigned NUM_WR = 4,
  parameter  int unsigned NUM_AL = 2,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_AL-1:0]        alloc_en,
  input  logic [NUM_AL*AW-1:0]     alloc_tag,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]  wr_data,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  output logic [AW:0]              busy_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;

  // Next busy vector: writes clear, allocates set (and win), flush clears all.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wr_en[k]) busy_nxt[wr_addr[k*AW +: AW]] = 1'b0;
    end
    for (int unsigned k = 0; k < NUM_AL; k++) begin
      if (alloc_en[k]) busy_nxt[alloc_tag[k*AW +: AW]] = 1'b1;
    end
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  // Popcount of next-state busy so busy_cnt tracks busy with no lag.
  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
    end
  end

  // Busy vector and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Data array; later loop iterations override earlier ones, so the highest
  // port index wins on an address conflict. Register 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
          mem[wr_addr[k*AW +: AW]] <= wr_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Read ports with same-cycle write bypass (highest matching port wins).
  always_comb begin
    logic [AW-1:0] ra;
    rd_data  = '0;
    rd_ready = '1;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      ra = rd_addr[p*AW +: AW];
      rd_data[p*WIDTH +: WIDTH] = mem[ra];
      rd_ready[p]               = ~busy[ra];
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] == ra)) begin
          rd_data[p*WIDTH +: WIDTH] = wr_data[k*WIDTH +: WIDTH];
          rd_ready[p]               = 1'b1;
        end
      end
      if (ra == '0) begin
        rd_data[p*WIDTH +: WIDTH] = '0;
        rd_ready[p]               = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prf_scoreboard.sv
// Scoreboard bench for prf_scoreboard: stimulus pushes expected read-port and
// busy_cnt values into a queue; a negedge monitor pops and compares them.
module tb_prf_scoreboard;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned NUM_RD = 8;
  localparam int unsigned NUM_WR = 4;
  localparam int unsigned NUM_AL = 2;
  localparam int unsigned AW     = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic [NUM_AL-1:0]       alloc_en;
  logic [NUM_AL*AW-1:0]    alloc_tag;
  logic [NUM_WR-1:0]       wr_en;
  logic [NUM_WR*AW-1:0]    wr_addr;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_ready;
  logic [AW:0]             busy_cnt;

  prf_scoreboard #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .NUM_AL(NUM_AL)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_en(alloc_en), .alloc_tag(alloc_tag),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_cnt;
    int          port;
    logic [31:0] data;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: every negedge, compare all expectations queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (e.is_cnt) begin
        if (busy_cnt !== (AW+1)'(e.data)) begin
          n_fail++;
          $display("FAIL %s: busy_cnt got %0d want %0d", e.name, busy_cnt, e.data);
        end
      end else begin
        if (rd_data[e.port*WIDTH +: WIDTH] !== e.data || rd_ready[e.port] !== e.rdy) begin
          n_fail++;
          $display("FAIL %s: port %0d got data=%h ready=%b want data=%h ready=%b",
                   e.name, e.port, rd_data[e.port*WIDTH +: WIDTH], rd_ready[e.port],
                   e.data, e.rdy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush    = 1'b0;
    alloc_en = '0;
    wr_en    = '0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic do_alloc(input int k, input logic [AW-1:0] t);
    alloc_en[k] = 1'b1;
    alloc_tag[k*AW +: AW] = t;
  endtask

  task automatic do_wr(input int k, input logic [AW-1:0] a, input logic [31:0] d);
    wr_en[k] = 1'b1;
    wr_addr[k*AW +: AW] = a;
    wr_data[k*WIDTH +: WIDTH] = d;
  endtask

  task automatic exp_rd(input string n, input int p, input logic [31:0] d, input logic r);
    exp_t e;
    e.name = n; e.is_cnt = 1'b0; e.port = p; e.data = d; e.rdy = r;
    q.push_back(e);
  endtask

  task automatic exp_cnt(input string n, input int c);
    exp_t e;
    e.name = n; e.is_cnt = 1'b1; e.port = 0; e.data = 32'(c); e.rdy = 1'b1;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; idle();
    alloc_tag = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    set_rd(0, 6'd0); set_rd(1, 6'd5); set_rd(2, 6'd63);
    exp_rd("rst_r0", 0, 32'h0, 1'b1);
    exp_rd("rst_r5", 1, 32'h0, 1'b1);
    exp_rd("rst_r63", 2, 32'h0, 1'b1);
    exp_cnt("rst_cnt", 0);
    tick();

    // Allocate 12 then writeback
    do_alloc(0, 6'd12); set_rd(0, 6'd12);
    exp_rd("alloc_same_cycle", 0, 32'h0, 1'b1);
    tick(); idle();
    exp_rd("alloc_busy", 0, 32'h0, 1'b0);
    exp_cnt("alloc_cnt", 1);
    tick();
    do_wr(1, 6'd12, 32'hDEADBEEF);
    exp_rd("wb_bypass", 0, 32'hDEADBEEF, 1'b1);
    exp_cnt("wb_cnt_before", 1);
    tick(); idle();
    exp_rd("wb_array", 0, 32'hDEADBEEF, 1'b1);
    exp_cnt("wb_cnt_after", 0);
    tick();

    // Write conflict on register 7
    do_wr(0, 6'd7, 32'h11); do_wr(3, 6'd7, 32'h33); set_rd(1, 6'd7);
    exp_rd("conflict_bypass", 1, 32'h33, 1'b1);
    tick(); idle();
    exp_rd("conflict_array", 1, 32'h33, 1'b1);
    tick();

    // Register 0 ignores alloc and write
    do_alloc(0, 6'd0); do_wr(2, 6'd0, 32'hFFFFFFFF); set_rd(2, 6'd0);
    exp_rd("r0_same_cycle", 2, 32'h0, 1'b1);
    tick(); idle();
    exp_rd("r0_after", 2, 32'h0, 1'b1);
    exp_cnt("r0_cnt", 0);
    tick();

    // Alloc and write to the same register in one cycle
    do_alloc(1, 6'd20); do_wr(0, 6'd20, 32'h55); set_rd(3, 6'd20);
    exp_rd("coll_bypass", 3, 32'h55, 1'b1);
    tick(); idle();
    exp_rd("coll_after", 3, 32'h55, 1'b0);
    exp_cnt("coll_cnt", 1);
    tick();

    // Allocate 3, 4, 5 then flush with a competing alloc of 9
    do_alloc(0, 6'd3); do_alloc(1, 6'd4);
    tick(); idle();
    do_alloc(0, 6'd5);
    set_rd(4, 6'd3); set_rd(5, 6'd4); set_rd(6, 6'd5); set_rd(7, 6'd9);
    tick(); idle();
    exp_rd("pre_flush_r3", 4, 32'h0, 1'b0);
    exp_rd("pre_flush_r5", 6, 32'h0, 1'b0);
    exp_cnt("pre_flush_cnt", 4);
    flush = 1'b1; do_alloc(1, 6'd9);
    tick(); idle();
    exp_rd("flush_r3", 4, 32'h0, 1'b1);
    exp_rd("flush_r4", 5, 32'h0, 1'b1);
    exp_rd("flush_r5", 6, 32'h0, 1'b1);
    exp_rd("flush_r9", 7, 32'h0, 1'b1);
    exp_rd("flush_r20", 3, 32'h55, 1'b1);
    exp_cnt("flush_cnt", 0);
    tick();

    // Write 9 then mid-run reset
    do_wr(2, 6'd9, 32'hAA);
    tick(); idle();
    exp_rd("w9_array", 7, 32'hAA, 1'b1);
    do_alloc(0, 6'd30);
    rst = 1'b1;
    tick(); idle();
    rst = 1'b0;
    exp_rd("rst_mid_r9", 7, 32'h0, 1'b1);
    exp_rd("rst_mid_r7", 1, 32'h0, 1'b1);
    exp_cnt("rst_mid_cnt", 0);
    tick();
    tick();

    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
